mmu_bus_arbiter: RTL and testbench
==================================

MMU_BUS_ARBITER -- requirements
Module: mmu_bus_arbiter

Interface
REQ-001 SHALL have parameter WATCHDOG, default 256, cycles an in-flight transfer may wait for s_ready before forced abort (range 2..65535).
REQ-002 SHALL have port clk  input  1  clock; all state changes on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have ports mX_req  input  1  master X (X=0 data MMU, X=1 fetch MMU) requests bus ownership.
REQ-005 SHALL have ports mX_gnt  output  1  slave grant forwarded to the owning master.
REQ-006 SHALL have ports mX_hrd  output  1  bus held by someone else; master X must not start a transfer.
REQ-007 SHALL have ports mX_a  input  32  physical address.
REQ-008 SHALL have ports mX_d  input  32  write data.
REQ-009 SHALL have ports mX_we / mX_rd  input  1 each  write / read strobe.
REQ-010 SHALL have ports mX_spo  output  32  read data.
REQ-011 SHALL have ports mX_ready  output  1  transfer complete.
REQ-012 SHALL have ports s_req, s_a(32), s_d(32), s_we, s_rd  output  muxed downstream request.
REQ-013 SHALL have ports s_gnt, s_hrd, s_ready (1 each), s_spo (32)  input  downstream responses.
REQ-014 SHALL have port bus_err  output  1  one-cycle pulse on watchdog abort.
REQ-015 SHALL have port err_master  output  1  owner index of last abort, held until next abort.

Function
REQ-016 SHALL implement states IDLE and OWN, with registered owner bit, registered last bit and watchdog counter wd of width clog2(WATCHDOG)+1.
REQ-017 IDLE: s_req/s_we/s_rd = 0, s_a/s_d = 0, mX_gnt = 0, mX_ready = 0, mX_spo = 0, mX_hrd = s_hrd.
REQ-018 IDLE with s_hrd = 0 and exactly one mX_req = 1: SHALL set owner <= X and enter OWN next cycle (1-cycle grant latency).
REQ-019 IDLE with both requests: SHALL grant !last (round-robin); s_hrd = 1 SHALL block all grants.
REQ-020 OWN: s_req, s_a, s_d, s_we, s_rd SHALL combinationally equal the owner's inputs; owner gnt = s_gnt, hrd = s_hrd, ready = s_ready, spo = s_spo.
REQ-021 OWN: non-owner SHALL see gnt = 0, ready = 0, spo = 0, hrd = 1.
REQ-022 In-flight = owner (rd | we) = 1 and s_ready = 0; wd SHALL increment each in-flight cycle and clear to 0 otherwise.
REQ-023 OWN with owner req = 0 and owner rd = we = 0: SHALL return to IDLE next cycle with last <= owner; handover to another waiting master therefore takes 2 cycles.
REQ-024 Owner req dropping while rd or we still asserted SHALL NOT release; release waits for strobes low.
REQ-025 wd reaching WATCHDOG-1 while in-flight: SHALL, that cycle, force s_rd = s_we = 0, assert owner ready = 1 with spo = 0, pulse bus_err, set err_master <= owner; next cycle IDLE, last <= owner, wd <= 0.
REQ-026 s_ready arriving in the same cycle as watchdog expiry: SHALL treat as normal completion, no bus_err.
REQ-027 mX_rd/mX_we from a non-owner SHALL be ignored and SHALL NOT reach s_*.

Reset
REQ-028 rst SHALL force state IDLE, owner = 0, last = 1 (m0 wins first tie), wd = 0, bus_err = 0, err_master = 0, taking priority over all events including an in-flight transfer, which is dropped without ready.

Verification
REQ-029 Both req rise same cycle after reset, s_gnt = 1 -> m0_gnt = 1 one cycle later, m1_hrd = 1; m0 drops req -> IDLE, then m1 granted 2 cycles after drop.
REQ-030 m0 reads 0x8000_1000, s_spo = 0xDEADBEEF, s_ready after 3 cycles -> m0_spo = 0xDEADBEEF with m0_ready, m1_spo = 0, no bus_err.
REQ-031 WATCHDOG = 4, m1 write with s_ready held 0 -> bus_err pulse on 4th in-flight cycle, m1_ready = 1, err_master = 1, s_we = 0 that cycle, IDLE next.
REQ-032 s_hrd = 1 in IDLE with m0_req = 1 for 10 cycles -> no grant, m0_hrd = 1; s_hrd drops -> m0 owns next cycle.
REQ-033 rst asserted mid-read by m1 -> next cycle IDLE, all outputs zero, m1_ready never asserted; subsequent tie grants m0.

Source files
------------

// File: rtl/mmu_bus_arbiter.sv
// Two-master bus arbiter for the data and fetch MMUs: round-robin ownership,
// combinational request muxing to a single downstream slave, and a watchdog
// that aborts transfers the slave never completes.
module mmu_bus_arbiter #(
    parameter int unsigned WATCHDOG = 256
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        m0_req,
    output logic        m0_gnt,
    output logic        m0_hrd,
    input  logic [31:0] m0_a,
    input  logic [31:0] m0_d,
    input  logic        m0_we,
    input  logic        m0_rd,
    output logic [31:0] m0_spo,
    output logic        m0_ready,

    input  logic        m1_req,
    output logic        m1_gnt,
    output logic        m1_hrd,
    input  logic [31:0] m1_a,
    input  logic [31:0] m1_d,
    input  logic        m1_we,
    input  logic        m1_rd,
    output logic [31:0] m1_spo,
    output logic        m1_ready,

    output logic        s_req,
    output logic [31:0] s_a,
    output logic [31:0] s_d,
    output logic        s_we,
    output logic        s_rd,
    input  logic        s_gnt,
    input  logic        s_hrd,
    input  logic        s_ready,
    input  logic [31:0] s_spo,

    output logic        bus_err,
    output logic        err_master
);

    localparam int unsigned WD_W = $clog2(WATCHDOG) + 1;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    state_t          state;
    logic            owner;
    logic            last;
    logic [WD_W-1:0] wd;

    logic        own_req;
    logic        own_we;
    logic        own_rd;
    logic [31:0] own_a;
    logic [31:0] own_d;
    logic        in_flight;
    logic        wd_expire;

    // Select the current owner's request signals
    always_comb begin
        own_req = owner ? m1_req : m0_req;
        own_we  = owner ? m1_we  : m0_we;
        own_rd  = owner ? m1_rd  : m0_rd;
        own_a   = owner ? m1_a   : m0_a;
        own_d   = owner ? m1_d   : m0_d;
        // A slave ready in the expiry cycle is a normal completion, not an abort
        in_flight = (state == OWN) && (own_rd || own_we) && !s_ready;
        wd_expire = in_flight && (wd == WD_W'(WATCHDOG - 1));
    end

    // Ownership FSM, round-robin tie memory, watchdog and abort record
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last       <= 1'b1;
            wd         <= '0;
            err_master <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    wd <= '0;
                    if (!s_hrd) begin
                        if (m0_req && m1_req) begin
                            owner <= ~last;
                            state <= OWN;
                        end else if (m0_req) begin
                            owner <= 1'b0;
                            state <= OWN;
                        end else if (m1_req) begin
                            owner <= 1'b1;
                            state <= OWN;
                        end
                    end
                end
                OWN: begin
                    if (wd_expire) begin
                        err_master <= owner;
                        last       <= owner;
                        wd         <= '0;
                        state      <= IDLE;
                    end else begin
                        wd <= in_flight ? wd + WD_W'(1) : '0;
                        // Release only once the owner has dropped its request and both strobes
                        if (!own_req && !own_rd && !own_we) begin
                            last  <= owner;
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Downstream mux and per-master response steering
    always_comb begin
        s_req    = 1'b0;
        s_a      = '0;
        s_d      = '0;
        s_we     = 1'b0;
        s_rd     = 1'b0;
        m0_gnt   = 1'b0;
        m1_gnt   = 1'b0;
        m0_hrd   = s_hrd;
        m1_hrd   = s_hrd;
        m0_ready = 1'b0;
        m1_ready = 1'b0;
        m0_spo   = '0;
        m1_spo   = '0;
        bus_err  = 1'b0;
        if (state == OWN) begin
            s_req   = own_req;
            s_a     = own_a;
            s_d     = own_d;
            s_we    = wd_expire ? 1'b0 : own_we;
            s_rd    = wd_expire ? 1'b0 : own_rd;
            bus_err = wd_expire;
            if (owner) begin
                m1_gnt   = s_gnt;
                m1_ready = wd_expire ? 1'b1 : s_ready;
                m1_spo   = wd_expire ? '0 : s_spo;
                m0_hrd   = 1'b1;
            end else begin
                m0_gnt   = s_gnt;
                m0_ready = wd_expire ? 1'b1 : s_ready;
                m0_spo   = wd_expire ? '0 : s_spo;
                m1_hrd   = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mmu_bus_arbiter.sv
// Directed bench for mmu_bus_arbiter with a short watchdog.
module tb_mmu_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m0_gnt, m0_hrd, m0_we, m0_rd, m0_ready;
    logic [31:0] m0_a, m0_d, m0_spo;
    logic        m1_req, m1_gnt, m1_hrd, m1_we, m1_rd, m1_ready;
    logic [31:0] m1_a, m1_d, m1_spo;
    logic        s_req, s_we, s_rd, s_gnt, s_hrd, s_ready;
    logic [31:0] s_a, s_d, s_spo;
    logic        bus_err, err_master;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mmu_bus_arbiter #(.WATCHDOG(4)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_gnt(m0_gnt), .m0_hrd(m0_hrd), .m0_a(m0_a), .m0_d(m0_d),
        .m0_we(m0_we), .m0_rd(m0_rd), .m0_spo(m0_spo), .m0_ready(m0_ready),
        .m1_req(m1_req), .m1_gnt(m1_gnt), .m1_hrd(m1_hrd), .m1_a(m1_a), .m1_d(m1_d),
        .m1_we(m1_we), .m1_rd(m1_rd), .m1_spo(m1_spo), .m1_ready(m1_ready),
        .s_req(s_req), .s_a(s_a), .s_d(s_d), .s_we(s_we), .s_rd(s_rd),
        .s_gnt(s_gnt), .s_hrd(s_hrd), .s_ready(s_ready), .s_spo(s_spo),
        .bus_err(bus_err), .err_master(err_master)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        m0_req = 0; m0_we = 0; m0_rd = 0; m0_a = '0; m0_d = '0;
        m1_req = 0; m1_we = 0; m1_rd = 0; m1_a = '0; m1_d = '0;
        s_gnt = 1'b1; s_hrd = 1'b0; s_ready = 1'b0; s_spo = '0;
        tick();
        tick();
        #1;
        chk("rst_bus_err", 32'(bus_err), 32'h0);
        chk("rst_err_master", 32'(err_master), 32'h0);
        chk("rst_m0_gnt", 32'(m0_gnt), 32'h0);
        chk("rst_s_req", 32'(s_req), 32'h0);
        chk("rst_m0_hrd", 32'(m0_hrd), 32'h0);

        // Simultaneous requests: m0 wins the first tie
        tick();
        rst = 1'b0;
        m0_req = 1; m1_req = 1;
        #1;
        chk("idle_no_gnt", 32'(m0_gnt), 32'h0);
        tick();
        #1;
        chk("tie_m0_gnt", 32'(m0_gnt), 32'h1);
        chk("tie_m1_hrd", 32'(m1_hrd), 32'h1);
        chk("tie_m1_gnt", 32'(m1_gnt), 32'h0);
        chk("tie_s_req", 32'(s_req), 32'h1);

        // m0 read, slave ready on the cycle the watchdog would expire
        m0_rd = 1; m0_a = 32'h8000_1000; s_spo = 32'hDEAD_BEEF;
        m1_rd = 1; m1_a = 32'h1234_5678;
        #1;
        chk("rd_s_a", s_a, 32'h8000_1000);
        chk("rd_s_rd", 32'(s_rd), 32'h1);
        tick();
        tick();
        tick();
        s_ready = 1'b1;
        #1;
        chk("rd_m0_spo", m0_spo, 32'hDEAD_BEEF);
        chk("rd_m0_ready", 32'(m0_ready), 32'h1);
        chk("rd_m1_spo", m1_spo, 32'h0);
        chk("rd_m1_ready", 32'(m1_ready), 32'h0);
        chk("rd_no_bus_err", 32'(bus_err), 32'h0);
        tick();
        m0_rd = 0; m1_rd = 0; s_ready = 0;
        #1;
        chk("rd_still_own", 32'(m0_gnt), 32'h1);

        // m0 drops request; m1 granted two cycles later
        tick();
        m0_req = 0;
        tick();
        #1;
        chk("drop_idle_m0_gnt", 32'(m0_gnt), 32'h0);
        chk("drop_idle_m1_gnt", 32'(m1_gnt), 32'h0);
        chk("drop_idle_m1_hrd", 32'(m1_hrd), 32'h0);
        tick();
        #1;
        chk("hand_m1_gnt", 32'(m1_gnt), 32'h1);
        chk("hand_m0_hrd", 32'(m0_hrd), 32'h1);

        // m1 write the slave never completes; request dropped but strobe held
        m1_we = 1; m1_req = 0; m1_d = 32'hCAFE_F00D;
        #1;
        chk("wr_s_we", 32'(s_we), 32'h1);
        chk("wr_s_d", s_d, 32'hCAFE_F00D);
        chk("wr_c1_bus_err", 32'(bus_err), 32'h0);
        tick();
        tick();
        #1;
        chk("wr_c3_bus_err", 32'(bus_err), 32'h0);
        chk("wr_c3_m1_gnt", 32'(m1_gnt), 32'h1);
        tick();
        #1;
        chk("wd_bus_err", 32'(bus_err), 32'h1);
        chk("wd_m1_ready", 32'(m1_ready), 32'h1);
        chk("wd_m1_spo", m1_spo, 32'h0);
        chk("wd_s_we", 32'(s_we), 32'h0);
        chk("wd_m0_ready", 32'(m0_ready), 32'h0);
        tick();
        m1_we = 0;
        #1;
        chk("wd_err_master", 32'(err_master), 32'h1);
        chk("wd_pulse_end", 32'(bus_err), 32'h0);
        chk("wd_idle_m1_gnt", 32'(m1_gnt), 32'h0);
        chk("wd_idle_s_req", 32'(s_req), 32'h0);

        // Slave hold blocks grant in IDLE
        s_hrd = 1; m0_req = 1;
        for (int i = 0; i < 10; i++) begin
            tick();
            #1;
            chk("hrd_m0_gnt", 32'(m0_gnt), 32'h0);
            chk("hrd_m0_hrd", 32'(m0_hrd), 32'h1);
        end
        s_hrd = 0;
        #1;
        chk("hrd_rel_still_idle", 32'(m0_gnt), 32'h0);
        tick();
        #1;
        chk("hrd_rel_m0_gnt", 32'(m0_gnt), 32'h1);
        chk("hrd_rel_s_req", 32'(s_req), 32'h1);
        m0_req = 0;
        tick();

        // Reset mid-read by m1; afterwards the tie goes to m0 again
        m1_req = 1;
        tick();
        m1_rd = 1; m1_a = 32'h0000_0040;
        #1;
        chk("rst_rd_m1_gnt", 32'(m1_gnt), 32'h1);
        tick();
        rst = 1;
        #1;
        chk("rst_rd_m1_ready", 32'(m1_ready), 32'h0);
        tick();
        #1;
        chk("rst_idle_m1_gnt", 32'(m1_gnt), 32'h0);
        chk("rst_idle_m1_ready", 32'(m1_ready), 32'h0);
        chk("rst_idle_s_rd", 32'(s_rd), 32'h0);
        chk("rst_idle_s_a", s_a, 32'h0);
        chk("rst_idle_err_master", 32'(err_master), 32'h0);
        chk("rst_idle_bus_err", 32'(bus_err), 32'h0);
        rst = 0; m1_rd = 0; m0_req = 1;
        tick();
        #1;
        chk("post_rst_m0_gnt", 32'(m0_gnt), 32'h1);
        chk("post_rst_m1_gnt", 32'(m1_gnt), 32'h0);
        chk("post_rst_m1_hrd", 32'(m1_hrd), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
